// File: rtl/quad_pkg.sv
// Shared types, constants and the quadrature direction helper for the encoder front end.
// Channel order inside quad_t is {A,B}.
package quad_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t QUAD_00 = 2'b00;
  localparam quad_t QUAD_01 = 2'b01;
  localparam quad_t QUAD_10 = 2'b10;
  localparam quad_t QUAD_11 = 2'b11;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef struct packed {
    logic legal;
    logic cw;
  } quad_dir_t;

  typedef enum logic [1:0] {
    ST_FILL1 = 2'd0,
    ST_FILL2 = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } prime_state_t;

  // legal means exactly one channel moved; cw is only meaningful when legal.
  function automatic quad_dir_t quad_dir(input quad_t prev, input quad_t cur);
    quad_dir_t r;
    r.legal = ^(prev ^ cur);
    r.cw    = 1'b0;
    case (prev)
      QUAD_00: r.cw = (cur == QUAD_10);
      QUAD_10: r.cw = (cur == QUAD_11);
      QUAD_11: r.cw = (cur == QUAD_01);
      QUAD_01: r.cw = (cur == QUAD_00);
      default: r.cw = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Control and result signals of the quadrature decoder, named from the decoder's side.
// The bench drives through master; the decoder attaches as slave.
interface quad_decoder_if #(
  parameter int ERR_W = 8
);

  logic             en_i;
  logic             opto_a_i;
  logic             opto_b_i;
  logic             clr_err_i;
  logic             step_o;
  logic             direction_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport master (
    output en_i,
    output opto_a_i,
    output opto_b_i,
    output clr_err_i,
    input  step_o,
    input  direction_o,
    input  err_o,
    input  err_cnt_o
  );

  modport slave (
    input  en_i,
    input  opto_a_i,
    input  opto_b_i,
    input  clr_err_i,
    output step_o,
    output direction_o,
    output err_o,
    output err_cnt_o
  );

endinterface

// File: rtl/quad_filter.sv
// One encoder channel: 2-FF synchroniser followed by a stability filter that accepts
// a new level only after it has been seen for FILTER_LEN consecutive cycles.
module quad_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic d_i,
  output logic sync_o,
  output logic q_o
);

  localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             meta_q;
  logic             sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // The count holds the number of cycles the new level has already been seen.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (load_i) begin
      filt_d = sync_q;
    end else if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sync_o = sync_q;
  assign q_o    = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: de-glitched channels, priming after reset, STEP/DIRECTION and
// illegal-transition reporting. Define QUAD_X4_EN to step on every legal transition.
//
//  state    | meaning
//  ST_FILL1 | first cycle after reset, synchroniser filling
//  ST_FILL2 | second cycle, synchroniser filling
//  ST_LOAD  | filters and prev state take the synchronised position
//  ST_RUN   | primed, decoding every cycle
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int ERR_W      = 8
) (
  input logic           clk,
  input logic           rst_n,
  quad_decoder_if.slave bus
);

  prime_state_t     st_q, st_d;
  logic             load;
  logic             primed;

  logic             sync_a, sync_b;
  logic             filt_a, filt_b;
  quad_t            cur;
  quad_t            prev_q, prev_d;
  quad_dir_t        dec;
  logic             changed;
  logic             legal_evt;
  logic             illegal_evt;
  logic             step_hit;

  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .d_i    (bus.opto_a_i),
    .sync_o (sync_a),
    .q_o    (filt_a)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .d_i    (bus.opto_b_i),
    .sync_o (sync_b),
    .q_o    (filt_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_FILL1;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    load = 1'b0;
    case (st_q)
      ST_FILL1: st_d = ST_FILL2;
      ST_FILL2: st_d = ST_LOAD;
      ST_LOAD: begin
        load = 1'b1;
        st_d = ST_RUN;
      end
      ST_RUN:   st_d = ST_RUN;
      default:  st_d = ST_FILL1;
    endcase
  end

  assign primed = (st_q == ST_RUN);

  assign cur         = {filt_a, filt_b};
  assign dec         = quad_dir(prev_q, cur);
  assign changed     = (prev_q != cur);
  assign legal_evt   = primed && changed && dec.legal;
  assign illegal_evt = primed && changed && !dec.legal;

`ifdef QUAD_X4_EN
  assign step_hit = legal_evt;
`else
  // One count per electrical cycle, anchored at the 00/10 boundary in both directions.
  assign step_hit = legal_evt &&
                    (( dec.cw && (prev_q == QUAD_00)) ||
                     (!dec.cw && (prev_q == QUAD_10)));
`endif

  always_comb begin
    prev_d    = prev_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir_q;
    err_cnt_d = err_cnt_q;

    // Position tracking runs regardless of EN so re-enabling cannot report stale motion.
    if (load) begin
      prev_d = {sync_a, sync_b};
    end else if (primed) begin
      prev_d = cur;
    end

    if (legal_evt) begin
      dir_d = dec.cw ? DIR_CW : DIR_CCW;
    end

    step_d = bus.en_i && step_hit;
    err_d  = bus.en_i && illegal_evt;

    if (bus.clr_err_i) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= QUAD_00;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      dir_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      prev_q    <= prev_d;
      step_q    <= step_d;
      err_q     <= err_d;
      dir_q     <= dir_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.step_o      = step_q;
  assign bus.err_o       = err_q;
  assign bus.direction_o = dir_q;
  assign bus.err_cnt_o   = err_cnt_q;

endmodule
